// File: rtl/sprite_scheduler_if.sv
// Sprite register write port: request/ack handshake carrying sprite index, field and value.
interface sprite_scheduler_if #(
  parameter int unsigned CORDW = 16
) ();
  logic                    wr_req;
  logic [1:0]              wr_idx;
  logic [1:0]              wr_field;
  logic signed [CORDW-1:0] wr_data;
  logic                    wr_ack;

  modport master (output wr_req, output wr_idx, output wr_field, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_idx, input wr_field, input wr_data, output wr_ack);
endinterface

// File: rtl/sprite_scheduler.sv
// Per-frame position update for NSPR bouncing sprites, one sprite every two cycles.
// Optional frame-overrun counter is built when SPR_SCHED_OVERRUN_EN is defined.
module sprite_scheduler #(
  parameter int unsigned CORDW     = 16,
  parameter int unsigned NSPR      = 4,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned SPR_DRAWW = 128,
  parameter int unsigned SPR_DRAWH = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  sprite_scheduler_if.slave       wr,
  output logic [NSPR*CORDW-1:0]   spr_x,
  output logic [NSPR*CORDW-1:0]   spr_y,
  output logic                    busy,
  output logic                    upd_done,
  output logic [7:0]              ovr_cnt
);

  localparam int unsigned IDXW = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam int unsigned LAST = NSPR - 1;

  localparam logic signed [CORDW:0]   LIM_X  = (CORDW+1)'(H_RES - SPR_DRAWW);
  localparam logic signed [CORDW:0]   LIM_Y  = (CORDW+1)'(V_RES - SPR_DRAWH);
  localparam logic signed [CORDW-1:0] RST_X  = CORDW'(H_RES/2 - SPR_DRAWW/2);
  localparam logic signed [CORDW-1:0] RST_Y  = CORDW'(V_RES/2 - SPR_DRAWH/2);
  localparam logic signed [CORDW-1:0] RST_VX = CORDW'(4);
  localparam logic signed [CORDW-1:0] RST_VY = CORDW'(0);

  typedef enum logic [1:0] {IDLE, CALC, STORE, DONE} state_t;

  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic signed [CORDW-1:0] x_q  [NSPR];
  logic signed [CORDW-1:0] y_q  [NSPR];
  logic signed [CORDW-1:0] vx_q [NSPR];
  logic signed [CORDW-1:0] vy_q [NSPR];

  logic signed [CORDW:0] nx_q, ny_q;

  logic busy_q;
  logic done_q;
  logic ack_q;
  logic wr_ack_c;

  // Grant only in IDLE, never with a competing frame, never back-to-back
  assign wr_ack_c  = !rst && (state_q == IDLE) && wr.wr_req && !frame && !ack_q;
  assign wr.wr_ack = wr_ack_c;

  assign busy     = busy_q;
  assign upd_done = done_q;

  // Next-state and sprite index sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (frame) begin
          state_d = CALC;
          idx_d   = '0;
        end
      end
      CALC: state_d = STORE;
      STORE: begin
        if (idx_q == IDXW'(LAST)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = CALC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and the widened candidate position of the current sprite
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      nx_q    <= '0;
      ny_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      ack_q   <= wr_ack_c;
      if (state_q == CALC) begin
        nx_q <= {x_q[idx_q][CORDW-1], x_q[idx_q]} + {vx_q[idx_q][CORDW-1], vx_q[idx_q]};
        ny_q <= {y_q[idx_q][CORDW-1], y_q[idx_q]} + {vy_q[idx_q][CORDW-1], vy_q[idx_q]};
      end
    end
  end

  // Sprite registers: bounce/clamp on STORE, field writes on acknowledged requests
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NSPR; i++) begin
      if (rst) begin
        x_q[i]  <= RST_X;
        y_q[i]  <= RST_Y;
        vx_q[i] <= RST_VX;
        vy_q[i] <= RST_VY;
      end else if ((state_q == STORE) && (idx_q == IDXW'(i))) begin
        if (nx_q[CORDW]) begin
          x_q[i]  <= '0;
          vx_q[i] <= -vx_q[i];
        end else if (nx_q > LIM_X) begin
          x_q[i]  <= LIM_X[CORDW-1:0];
          vx_q[i] <= -vx_q[i];
        end else begin
          x_q[i]  <= nx_q[CORDW-1:0];
        end
        if (ny_q[CORDW]) begin
          y_q[i]  <= '0;
          vy_q[i] <= -vy_q[i];
        end else if (ny_q > LIM_Y) begin
          y_q[i]  <= LIM_Y[CORDW-1:0];
          vy_q[i] <= -vy_q[i];
        end else begin
          y_q[i]  <= ny_q[CORDW-1:0];
        end
      end else if (wr_ack_c && (wr.wr_idx == 2'(i))) begin
        unique case (wr.wr_field)
          2'd0:    x_q[i]  <= wr.wr_data;
          2'd1:    y_q[i]  <= wr.wr_data;
          2'd2:    vx_q[i] <= wr.wr_data;
          default: vy_q[i] <= wr.wr_data;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_flat
    assign spr_x[g*CORDW +: CORDW] = x_q[g];
    assign spr_y[g*CORDW +: CORDW] = y_q[g];
  end

`ifdef SPR_SCHED_OVERRUN_EN
  logic [7:0] ovr_q;

  // Frames arriving mid-update are counted; writing sprite 0 x clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (frame && (state_q != IDLE)) begin
      if (ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end else if (wr_ack_c && (wr.wr_idx == 2'd0) && (wr.wr_field == 2'd0)) begin
      ovr_q <= '0;
    end
  end

  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = 8'd0;
`endif

endmodule
